// File: rtl/updi_seq_pkg.sv
// -----------------------------------------------------------------------------
// updi_seq_pkg
// Shared types and constants for the UPDI line sequencer.
//   cmd_op_e    : host command opcodes carried on cmd_op
//   seq_state_e : sequencer FSM states (also visible on the dbg_state port)
//   DEF_*       : default timing constants for BREAK / GAP lengths
//   bits_reached: tests whether a bit counter is on the last bit of a phase
// -----------------------------------------------------------------------------
package updi_seq_pkg;

  typedef enum logic [1:0] {
    IDLE_BITS    = 2'd0,
    BREAK        = 2'd1,
    DOUBLE_BREAK = 2'd2,
    RESERVED     = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HOLD   = 3'd1,
    BRK1   = 3'd2,
    GAP    = 3'd3,
    BRK2   = 3'd4,
    TX_OWN = 3'd5
  } seq_state_e;

  localparam int unsigned DEF_DIV_W       = 16;
  localparam int unsigned DEF_DEFAULT_DIV = 16;
  localparam int unsigned DEF_BREAK_BITS  = 12;
  localparam int unsigned DEF_GAP_BITS    = 2;

  // True when the bit that is currently ending is the target-th bit of the
  // phase (cnt counts completed bits, starting at 0). Widened to 9 bits so a
  // target of 255 does not wrap.
  function automatic logic bits_reached(input logic [7:0] cnt,
                                        input logic [7:0] target);
    return ({1'b0, cnt} + 9'd1) == {1'b0, target};
  endfunction

endpackage

// File: rtl/updi_line_sequencer_baud_tick_gen.sv
// -----------------------------------------------------------------------------
// baud_tick_gen
// Runtime-programmable bit-period strobe.
//   clk_i      : system clock
//   rst_i      : synchronous active-high reset
//   baud_div_i : cycles per bit; 0 is treated as 1
//   clear_i    : restart the bit period (counter to 0, divisor reloaded)
//   bit_tick_o : registered one-cycle pulse in the cycle after the last
//                cycle of a bit period
//   wrap_o     : combinational "this is the last cycle of the bit period";
//                lets co-located logic act on the same edge that raises
//                bit_tick_o
// The divisor is only sampled at bit boundaries (wrap) and on clear, so a
// divisor change never shortens or stretches a bit already in progress.
// -----------------------------------------------------------------------------
module baud_tick_gen #(
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned DEFAULT_DIV = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [DIV_W-1:0] baud_div_i,
  input  logic             clear_i,
  output logic             bit_tick_o,
  output logic             wrap_o
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic [DIV_W-1:0] div_sel;
  logic             tick_q;
  logic             tick_d;

  assign div_sel = (baud_div_i == '0) ? DIV_W'(1) : baud_div_i;
  assign wrap_o  = (cnt_q == (div_q - DIV_W'(1)));

  always_comb begin
    cnt_d  = cnt_q + DIV_W'(1);
    div_d  = div_q;
    tick_d = 1'b0;
    if (clear_i) begin
      // A restarted period must not emit a stray tick for the old one.
      cnt_d = '0;
      div_d = div_sel;
    end else if (wrap_o) begin
      cnt_d  = '0;
      div_d  = div_sel;
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      div_q  <= DIV_W'(DEFAULT_DIV);
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      tick_q <= tick_d;
    end
  end

  assign bit_tick_o = tick_q;

endmodule

// File: rtl/updi_line_sequencer.sv
// -----------------------------------------------------------------------------
// updi_line_sequencer
// Owns the single-wire UPDI line. Executes line-conditioning commands (idle
// bits, BREAK, double BREAK) and grants the line to the UART TX datapath,
// which shares the bit strobe generated here.
//   clk_in     : system clock
//   rst        : synchronous active-high reset
//   baud_div   : cycles per bit (0 treated as 1)
//   cmd_valid/cmd_ready/cmd_op/cmd_len : host command channel
//   cmd_done   : one-cycle pulse when a command finishes
//   cmd_err    : one-cycle pulse alongside cmd_done for the reserved opcode
//   tx_req     : TX datapath requests the line (level)
//   tx_gnt     : TX datapath owns the line
//   tx_line    : TX serial data, forwarded to the line while granted
//   bit_tick   : one-cycle pulse at the end of each bit period
//   line_out   : line drive, 1 = released/high
//   dbg_state  : current FSM state
//
// Handshakes: a command transfers on any cycle where cmd_valid && cmd_ready;
// cmd_op/cmd_len are only sampled on that cycle. cmd_ready is high exactly
// while the FSM is IDLE. tx_req is a level: the line is granted on the cycle
// after tx_req is seen in IDLE with no command pending, and released on the
// cycle after tx_req is seen low. A pending command always wins over tx_req.
// -----------------------------------------------------------------------------
module updi_line_sequencer
  import updi_seq_pkg::*;
#(
  parameter int unsigned DIV_W       = DEF_DIV_W,
  parameter int unsigned DEFAULT_DIV = DEF_DEFAULT_DIV,
  parameter int unsigned BREAK_BITS  = DEF_BREAK_BITS,
  parameter int unsigned GAP_BITS    = DEF_GAP_BITS
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [7:0]       cmd_len,
  output logic             cmd_done,
  output logic             cmd_err,
  input  logic             tx_req,
  output logic             tx_gnt,
  input  logic             tx_line,
  output logic             bit_tick,
  output logic             line_out,
  output seq_state_e       dbg_state
);

  localparam logic [7:0] BREAK_T = 8'(BREAK_BITS);
  localparam logic [7:0] GAP_T   = 8'(GAP_BITS);

  seq_state_e state_q;
  logic       line_q;
  logic       gnt_q;
  logic       done_q;
  logic       err_q;
  logic       dbl_q;
  logic [7:0] len_q;
  logic [7:0] bit_cnt_q;
  logic [7:0] bit_cnt_d;
  logic [7:0] target;
  logic       wrap;
  logic       seq_clear;
  logic       phase_last;

  // Restart the bit period whenever the line changes hands (command accept
  // or TX grant) so every owned bit is full length from its first cycle.
  assign seq_clear = (state_q == IDLE) && (cmd_valid || tx_req);

  baud_tick_gen #(
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_tick (
    .clk_i      (clk_in),
    .rst_i      (rst),
    .baud_div_i (baud_div),
    .clear_i    (seq_clear),
    .bit_tick_o (bit_tick),
    .wrap_o     (wrap)
  );

  // Bit count target of the active phase.
  always_comb begin
    target = len_q;
    case (state_q)
      BRK1, BRK2: target = BREAK_T;
      GAP:        target = GAP_T;
      default:    target = len_q;
    endcase
  end

  // The phase decision uses the wrap of the final bit (the same edge that
  // raises bit_tick), so the line changes exactly when the last bit ends.
  assign phase_last = wrap && bits_reached(bit_cnt_q, target);

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    if (phase_last) begin
      bit_cnt_d = '0;
    end else if (wrap) begin
      bit_cnt_d = bit_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q   <= IDLE;
      line_q    <= 1'b1;
      gnt_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      dbl_q     <= 1'b0;
      len_q     <= '0;
      bit_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          line_q    <= 1'b1;
          gnt_q     <= 1'b0;
          bit_cnt_q <= '0;
          if (cmd_valid) begin
            case (cmd_op_e'(cmd_op))
              IDLE_BITS: begin
                if (cmd_len == 8'd0) begin
                  done_q <= 1'b1;
                end else begin
                  state_q <= HOLD;
                  len_q   <= cmd_len;
                end
              end
              BREAK: begin
                state_q <= BRK1;
                dbl_q   <= 1'b0;
                line_q  <= 1'b0;
              end
              DOUBLE_BREAK: begin
                state_q <= BRK1;
                dbl_q   <= 1'b1;
                line_q  <= 1'b0;
              end
              default: begin
                done_q <= 1'b1;
                err_q  <= 1'b1;
              end
            endcase
          end else if (tx_req) begin
            state_q <= TX_OWN;
            gnt_q   <= 1'b1;
          end
        end

        HOLD: begin
          bit_cnt_q <= bit_cnt_d;
          line_q    <= 1'b1;
          if (phase_last) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end

        BRK1: begin
          bit_cnt_q <= bit_cnt_d;
          line_q    <= 1'b0;
          if (phase_last) begin
            line_q <= 1'b1;
            if (dbl_q) begin
              state_q <= GAP;
            end else begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end
        end

        GAP: begin
          bit_cnt_q <= bit_cnt_d;
          line_q    <= 1'b1;
          if (phase_last) begin
            state_q <= BRK2;
            line_q  <= 1'b0;
          end
        end

        BRK2: begin
          bit_cnt_q <= bit_cnt_d;
          line_q    <= 1'b0;
          if (phase_last) begin
            state_q <= IDLE;
            line_q  <= 1'b1;
            done_q  <= 1'b1;
            dbl_q   <= 1'b0;
          end
        end

        TX_OWN: begin
          // An early drop of tx_req is the datapath's problem; the line is
          // still released cleanly on the next cycle.
          if (tx_req) begin
            line_q <= tx_line;
            gnt_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
            line_q  <= 1'b1;
            gnt_q   <= 1'b0;
          end
        end

        default: begin
          state_q <= IDLE;
          line_q  <= 1'b1;
          gnt_q   <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign cmd_done  = done_q;
  assign cmd_err   = err_q;
  assign tx_gnt    = gnt_q;
  assign line_out  = line_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_updi_line_sequencer.sv
module tb_updi_line_sequencer;
  import updi_seq_pkg::*;

  localparam int BRK_B = 12;
  localparam int GAP_B = 2;

  // ---------------- clock / reset ----------------
  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] baud_div = 16'd16;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'd0;
  logic [7:0]  cmd_len = 8'd0;
  logic        tx_req = 1'b0;
  logic        tx_line = 1'b1;
  logic        cmd_ready;
  logic        cmd_done;
  logic        cmd_err;
  logic        tx_gnt;
  logic        bit_tick;
  logic        line_out;
  seq_state_e  dbg_state;

  always #5 clk_in = ~clk_in;

  updi_line_sequencer dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .baud_div  (baud_div),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .cmd_done  (cmd_done),
    .cmd_err   (cmd_err),
    .tx_req    (tx_req),
    .tx_gnt    (tx_gnt),
    .tx_line   (tx_line),
    .bit_tick  (bit_tick),
    .line_out  (line_out),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [0:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Number of bit periods a command occupies the line.
  function automatic int model_bits(input logic [1:0] op, input logic [7:0] len);
    case (op)
      2'd0:    return int'(len);
      2'd1:    return BRK_B;
      2'd2:    return 2 * BRK_B + GAP_B;
      default: return 0;
    endcase
  endfunction

  function automatic int eff_div(input logic [15:0] div);
    return (div == 16'd0) ? 1 : int'(div);
  endfunction

  // Expected line level for every cycle from T+1 until the command ends.
  function automatic void build_wave(input logic [1:0] op, input logic [7:0] len,
                                     input logic [15:0] div);
    int d;
    d = eff_div(div);
    exp_q.delete();
    case (op)
      2'd0: repeat (int'(len) * d) exp_q.push_back(1'b1);
      2'd1: repeat (BRK_B * d) exp_q.push_back(1'b0);
      2'd2: begin
        repeat (BRK_B * d) exp_q.push_back(1'b0);
        repeat (GAP_B * d) exp_q.push_back(1'b1);
        repeat (BRK_B * d) exp_q.push_back(1'b0);
      end
      default: ;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!cmd_ready && n < 400) begin
      step();
      n++;
    end
    check("wait_ready", cmd_ready, 1);
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [7:0] len, input logic [15:0] div,
                         input int done_at, input logic err, input int exp_ticks);
    int ticks;
    logic e;
    baud_div = div;
    tx_req   = 1'b0;
    wait_ready();
    build_wave(op, len, div);
    cmd_op    = op;
    cmd_len   = len;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    ticks = 0;
    for (int c = 1; c < done_at; c++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b1;
      check("line", line_out, e);
      check("busy_ready", cmd_ready, 0);
      check("early_done", cmd_done, 0);
      check("busy_gnt", tx_gnt, 0);
      ticks += int'(bit_tick);
      step();
    end
    ticks += int'(bit_tick);
    check("done", cmd_done, 1);
    check("err", cmd_err, err);
    check("line_released", line_out, 1);
    check("ready_after", cmd_ready, 1);
    check("tick_count", ticks, exp_ticks);
    exp_q.delete();
    step();
    check("done_pulse", cmd_done, 0);
  endtask

  task automatic tx_session(input int nc);
    logic drv;
    wait_ready();
    tx_line = 1'b1;
    tx_req  = 1'b1;
    step();
    check("gnt_rise", tx_gnt, 1);
    check("gnt_ready", cmd_ready, 0);
    check("gnt_line", line_out, 1);
    for (int k = 0; k < nc; k++) begin
      tx_line = 1'($urandom_range(0, 1));
      drv = tx_line;
      step();
      check("tx_follow", line_out, drv);
      check("tx_gnt_hold", tx_gnt, 1);
    end
    tx_req  = 1'b0;
    tx_line = 1'b1;
    step();
    check("gnt_drop", tx_gnt, 0);
    check("tx_release", line_out, 1);
    check("tx_ready", cmd_ready, 1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  op;
    logic [7:0]  len;
    logic [15:0] div;
    int          done_at;
    logic        err;
    int          ticks;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, first, ticks;
    logic drv;
    logic [1:0] op;
    logic [7:0] len;
    logic [15:0] div;
    int bits;

    vecs[0] = '{op: 2'd1, len: 8'd0, div: 16'd4, done_at: 49,  err: 1'b0, ticks: 12};
    vecs[1] = '{op: 2'd2, len: 8'd0, div: 16'd4, done_at: 105, err: 1'b0, ticks: 26};
    vecs[2] = '{op: 2'd0, len: 8'd3, div: 16'd5, done_at: 16,  err: 1'b0, ticks: 3};
    vecs[3] = '{op: 2'd0, len: 8'd0, div: 16'd4, done_at: 1,   err: 1'b0, ticks: 0};
    vecs[4] = '{op: 2'd3, len: 8'd5, div: 16'd4, done_at: 1,   err: 1'b1, ticks: 0};
    vecs[5] = '{op: 2'd1, len: 8'd0, div: 16'd0, done_at: 13,  err: 1'b0, ticks: 12};
    vecs[6] = '{op: 2'd2, len: 8'd0, div: 16'd1, done_at: 27,  err: 1'b0, ticks: 26};
    vecs[7] = '{op: 2'd0, len: 8'd1, div: 16'd3, done_at: 4,   err: 1'b0, ticks: 1};
    vecs[8] = '{op: 2'd0, len: 8'd7, div: 16'd2, done_at: 15,  err: 1'b0, ticks: 7};

    // Reset state
    rst = 1'b1;
    baud_div = 16'd16;
    repeat (3) step();
    check("rst_line", line_out, 1);
    check("rst_gnt", tx_gnt, 0);
    check("rst_done", cmd_done, 0);
    check("rst_err", cmd_err, 0);
    check("rst_tick", bit_tick, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_state", dbg_state, IDLE);
    rst = 1'b0;

    // Default divisor of 16 after reset: first tick 16 cycles in.
    n = 0;
    first = -1;
    for (int i = 0; i < 64; i++) begin
      if (bit_tick) begin
        n++;
        if (first < 0) first = i;
      end
      step();
    end
    check("first_tick", first, 16);
    check("tick_rate", n, 3);

    // Table-driven commands
    for (int i = 0; i < 9; i++) begin
      run_cmd(vecs[i].op, vecs[i].len, vecs[i].div, vecs[i].done_at, vecs[i].err, vecs[i].ticks);
    end

    // Command and tx_req together: BREAK first, then grant.
    baud_div = 16'd2;
    wait_ready();
    cmd_op = 2'd1; cmd_len = 8'd0; cmd_valid = 1'b1;
    tx_req = 1'b1; tx_line = 1'b1;
    step();
    cmd_valid = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      check("arb_line", line_out, 0);
      check("arb_no_gnt", tx_gnt, 0);
      step();
    end
    check("arb_done", cmd_done, 1);
    check("arb_gnt_wait", tx_gnt, 0);
    check("arb_line_rel", line_out, 1);
    step();
    check("arb_gnt", tx_gnt, 1);
    check("arb_ready", cmd_ready, 0);
    for (int k = 0; k < 6; k++) begin
      tx_line = k[0];
      drv = tx_line;
      step();
      check("arb_follow", line_out, drv);
    end
    tx_req = 1'b0;
    tx_line = 1'b1;
    step();
    check("arb_gnt_drop", tx_gnt, 0);
    check("arb_release", line_out, 1);

    // Divisor 4 -> 8 mid-BREAK: two 4-cycle bits, then ten 8-cycle bits.
    baud_div = 16'd4;
    wait_ready();
    cmd_op = 2'd1; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    ticks = 0;
    for (int c = 1; c <= 88; c++) begin
      if (c == 6) baud_div = 16'd8;
      check("div_chg_line", line_out, 0);
      if (c == 9)  check("div_chg_tick9", bit_tick, 1);
      if (c == 13) check("div_chg_tick13", bit_tick, 0);
      if (c == 17) check("div_chg_tick17", bit_tick, 1);
      ticks += int'(bit_tick);
      step();
    end
    ticks += int'(bit_tick);
    check("div_chg_done", cmd_done, 1);
    check("div_chg_rel", line_out, 1);
    check("div_chg_ticks", ticks, 12);

    // Reset ten cycles into a BREAK
    baud_div = 16'd4;
    wait_ready();
    cmd_op = 2'd1; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      check("rstmid_line", line_out, 0);
      if (c < 10) step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstmid_release", line_out, 1);
    check("rstmid_ready", cmd_ready, 1);
    for (int c = 0; c < 60; c++) begin
      check("rstmid_no_done", cmd_done, 0);
      step();
    end

    // Reset while TX owns the line
    tx_session(3);
    tx_req = 1'b1;
    step();
    check("rsttx_gnt", tx_gnt, 1);
    tx_line = 1'b0;
    step();
    check("rsttx_low", line_out, 0);
    rst = 1'b1;
    tx_req = 1'b0;
    step();
    rst = 1'b0;
    tx_line = 1'b1;
    check("rsttx_gnt_drop", tx_gnt, 0);
    check("rsttx_release", line_out, 1);
    step();

    // Randomized commands and TX sessions against the model
    for (int it = 0; it < 40; it++) begin
      op   = 2'($urandom_range(0, 3));
      len  = 8'($urandom_range(0, 6));
      div  = 16'($urandom_range(0, 5));
      bits = model_bits(op, len);
      run_cmd(op, len, div, bits * eff_div(div) + 1, (op == 2'd3), bits);
      if ($urandom_range(0, 2) == 0) tx_session($urandom_range(2, 12));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/updi_line_sequencer.md
Name: updi_line_sequencer

Overview:
Owns the single-wire UPDI line and its bit-timing resource. Generates a runtime-programmable bit-period strobe and executes line-conditioning commands (idle bits, BREAK, double BREAK) from the host-side controller. Arbitrates line ownership between those commands and the UART TX datapath, which shares the same bit strobe.

Parameters:
DIV_W, 16, width of baud_div and internal cycle counter
DEFAULT_DIV, 16, bit period (clk cycles) loaded at reset
BREAK_BITS, 12, bit periods the line is held low per BREAK
GAP_BITS, 2, high bit periods between the two BREAKs of a double BREAK

Ports:
clk_in  in  1  system clock
rst  in  1  synchronous active-high reset
baud_div  in  DIV_W  cycles per bit; 0 treated as 1
cmd_valid  in  1  command request
cmd_ready  out  1  sequencer idle, can accept command
cmd_op  in  2  0=IDLE_BITS, 1=BREAK, 2=DOUBLE_BREAK, 3=reserved
cmd_len  in  8  bit count for IDLE_BITS
cmd_done  out  1  one-cycle pulse, command finished
cmd_err  out  1  one-cycle pulse with cmd_done for reserved op
tx_req  in  1  TX datapath requests line (level)
tx_gnt  out  1  TX owns line
tx_line  in  1  TX serial data, driven to line while granted
bit_tick  out  1  one-cycle pulse at end of each bit period
line_out  out  1  UPDI line drive (1 = released/high)

Behaviour:
- Clock and reset: one clock, clk_in. Reset is synchronous and active-high on rst.
- Reset values: state IDLE, line_out=1, tx_gnt=0, cmd_done=0, cmd_err=0, bit_tick=0, cycle counter=0, div_q=DEFAULT_DIV.
- Registered outputs: all outputs are registered except cmd_ready.
- cmd_ready: combinational, equals (state==IDLE).
- Tick generator:
  - Counter runs 0..div_q-1 continuously.
  - bit_tick asserts in the cycle after the counter equals div_q-1.
  - div_q reloads from max(baud_div,1) on every wrap, on command accept and on a grant.
  - Counter clears to 0 on command accept and on a grant, so bit periods are phase-aligned to line ownership.
- States: IDLE, HOLD, BRK1, GAP, BRK2, TX_OWN.
- IDLE:
  - line_out=1.
  - On cmd_valid&&cmd_ready (accept cycle T), commands have priority over tx_req.
  - op0 with cmd_len>0 -> HOLD.
  - op0 with cmd_len=0 -> stay IDLE; cmd_done at T+1; line unchanged.
  - op1 -> BRK1.
  - op2 -> BRK1 with double flag set.
  - op3 -> stay IDLE; cmd_done and cmd_err at T+1.
  - Else, if tx_req -> TX_OWN, with tx_gnt=1 from T+1.
- HOLD:
  - line_out=1 for cmd_len*div_q cycles starting T+1.
  - Then IDLE; cmd_done pulses in the first IDLE cycle.
- BRK1:
  - line_out=0 for exactly BREAK_BITS*div_q cycles starting T+1.
  - Then GAP if double, else IDLE with cmd_done.
- GAP: line_out=1 for GAP_BITS*div_q cycles, then BRK2.
- BRK2: line_out=0 for BREAK_BITS*div_q cycles, then IDLE with cmd_done.
- Bit counting: an 8-bit bit counter increments on each bit_tick. A phase ends on the tick where the counter reaches its target; the counter then resets.
- TX_OWN:
  - line_out follows tx_line with one register stage; tx_gnt=1; cmd_ready=0.
  - When tx_req falls, return to IDLE next cycle: tx_gnt=0, line_out=1.
  - tx_req must stay high until the final stop bit's bit_tick. Early release is the TX datapath's error; the sequencer still releases the line.
- Simultaneous cmd_valid and tx_req in IDLE: command accepted. Grant is evaluated again once back in IDLE, with tx_req still high.
- baud_div changes mid-command take effect only at the next bit boundary.
- Reset mid-operation:
  - Line released (1) the cycle after the reset edge.
  - No cmd_done for the aborted command.
  - tx_gnt drops immediately.

Decomposition:
- Package updi_seq_pkg:
  - cmd_op_e enum (IDLE_BITS, BREAK, DOUBLE_BREAK, RESERVED).
  - seq_state_e enum.
  - Default constants for BREAK_BITS and GAP_BITS.
- Sub-module baud_tick_gen:
  - Runtime divisor, synchronous clear input, registered one-cycle bit_tick.
  - Isolates the tick generator so the UART RX/TX can instantiate it stand-alone.

Test Plan:
- BREAK: baud_div=4, op=1 -> line_out low exactly 48 cycles starting T+1; 12 bit_ticks; single cmd_done on cycle T+49; cmd_ready low in between.
- Double BREAK: baud_div=4, GAP_BITS=2 -> low 48, high 8, low 48 cycles; cmd_done once at T+105; cmd_err=0.
- IDLE_BITS: baud_div=5, cmd_len=3 -> line_out high; cmd_done at T+16.
- Zero-length and reserved commands:
  - cmd_len=0 -> cmd_done at T+1, no line change.
  - op=3 -> cmd_done=cmd_err=1 at T+1.
- Divisor edge cases:
  - baud_div=0 -> bit_tick every cycle; BREAK is 12 cycles low.
  - baud_div changed 4->8 mid-BREAK -> new period applies from the next bit.
- Arbitration and reset:
  - cmd_valid(op=1) and tx_req rise together with baud_div=2 -> BREAK executes first; tx_gnt=1 on the cycle after cmd_done; line_out tracks tx_line delayed 1 cycle; tx_req low -> tx_gnt=0 next cycle.
  - rst asserted 10 cycles into a BREAK -> line_out=1 the next cycle and no cmd_done.
